mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// CPU-side initiator for the byte-wide, big-endian data memory. Accepts 16-bit load/store
// requests from the datapath over a valid/ready handshake and splits each one into two byte
// accesses: the high byte goes to address A and the low byte to address A+1.
// Returns a single-cycle response pulse carrying the read data or a write acknowledgement.
// Sits between the execute stage and the data memory, and owns the memory's MemRead/MemWrite strobes.
// PARAMETERS
// ADDR_W     7    memory byte-address width; memory holds 2**ADDR_W bytes
// MEM_BYTES  128  highest legal byte address + 1; must be <= 2**ADDR_W
// PORTS
// Clock      in   1       system clock, rising edge
// Reset_n    in   1       asynchronous active-low reset
// ReqValid   in   1       request present
// ReqReady   out  1       unit can accept; equals (state==IDLE)
// ReqWrite   in   1       1=store, 0=load
// ReqAddr    in   16      byte address of the high byte
// ReqWData   in   16      store data
// RspValid   out  1       one-cycle completion pulse
// RspData    out  16      load result; 16'h0000 for stores and errors
// RspErr     out  1       request rejected; no memory access made (valid with RspValid)
// MemAddr    out  ADDR_W  byte address to memory
// MemWData   out  8       byte write data
// MemRead    out  1       byte read strobe; memory returns MemRData after 1 clock (synchronous)
// MemWrite   out  1       byte write strobe; committed on the rising edge
// MemRData   in   8       byte read data
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; ReqReady=1; RspValid=0; RspErr=0; RspData=0; MemRead=0;
//   MemWrite=0; MemAddr=0; MemWData=0. A byte already committed mid-store stays in memory.
// - Accept: ReqValid & ReqReady on an edge latches ReqWrite/ReqAddr/ReqWData. ReqReady stays low until RESP ends.
// - Range check at accept: ReqAddr+1 >= MEM_BYTES -> go to RESP with RspErr=1; no strobes are issued.
// - Store: WR_HI (MemWrite=1, MemAddr=A, MemWData=WData[15:8]) -> WR_LO (MemWrite=1,
//   MemAddr=A+1, MemWData=WData[7:0]) -> RESP. Latency: accept edge + 3 cycles to RspValid.
// - Load: RD_HI (MemRead=1, MemAddr=A) -> RD_LO (MemRead=1, MemAddr=A+1; latch MemRData into
//   RspData[15:8] at the end of the cycle) -> RD_CAP (strobes low; latch MemRData into RspData[7:0]) -> RESP.
//   Latency: 4 cycles to RspValid.
// - RESP: RspValid=1 for exactly one cycle, then IDLE. RspData/RspErr hold until the next accept.
// - A+1 is computed in ADDR_W bits. Bits of ReqAddr above ADDR_W must be 0; otherwise the request takes the error path.
// - MemRead and MemWrite are never high in the same cycle. Both are low in IDLE, RD_CAP and RESP.
// - ReqValid while busy is ignored; the requester must hold it until it sees ReqReady.
// - Back-to-back: ReqValid held high across RESP is accepted in the following IDLE cycle (1 idle cycle minimum).
// CONFIGURATION
// ALIGN_CHECK_EN defined: an odd ReqAddr (bit0=1) takes the error path (RspErr=1, no strobes),
//   alongside the range check.
// ALIGN_CHECK_EN undefined: odd addresses are legal, and the two bytes straddle a word boundary normally.
// TESTING
// - Reset: Reset_n=0 mid-RD_LO -> state IDLE, all strobes 0, ReqReady=1 asynchronously.
// - Store A=0x10, D=0xBEEF -> MemWrite at 0x10=0xBE then 0x11=0xEF on consecutive cycles;
//   RspValid on the 3rd cycle after accept, RspErr=0.
// - Load A=0x10 after the store above -> RspData=0xBEEF, RspValid on the 4th cycle after accept.
// - A=0x7F (MEM_BYTES=128) -> RspErr=1, RspData=0, no MemRead/MemWrite pulse at any time.
// - A=0x21: with ALIGN_CHECK_EN -> RspErr=1, no strobes; without it -> load returns {mem[0x21],mem[0x22]}.
// - ReqValid held for 3 stores -> exactly 3 accepts, 6 MemWrite pulses, ReqReady never high during a transfer.

Source files
------------

// File: rtl/mem_access_unit.sv
// Splits 16-bit load/store requests into two big-endian byte accesses (high byte at A, low at A+1).
// Optional ALIGN_CHECK_EN: odd request addresses are rejected through the error path.
module mem_access_unit #(
  parameter int ADDR_W    = 7,
  parameter int MEM_BYTES = 128
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [15:0]       ReqAddr,
  input  logic [15:0]       ReqWData,
  output logic              RspValid,
  output logic [15:0]       RspData,
  output logic              RspErr,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [7:0]        MemWData,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [7:0]        MemRData
);

  typedef enum logic [2:0] {
    IDLE,
    WR_HI,
    WR_LO,
    RD_HI,
    RD_LO,
    RD_CAP,
    RESP
  } state_t;

  localparam logic [16:0]       MEM_LIM  = 17'(MEM_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_lo;
  logic [15:0]       wdata_q;
  logic [16:0]       addr_end;
  logic              accept;
  logic              align_err;
  logic              req_err;

  assign accept   = ReqValid && ReqReady;
  // End address is widened so 16'hFFFF + 1 cannot wrap into the legal range.
  assign addr_end = {1'b0, ReqAddr} + 17'd1;
  // Low-byte address wraps within the memory address width.
  assign addr_lo  = addr_q + ADDR_ONE;

`ifdef ALIGN_CHECK_EN
  assign align_err = ReqAddr[0];
`else
  assign align_err = 1'b0;
`endif

  assign req_err = (addr_end >= MEM_LIM) || ((ReqAddr >> ADDR_W) != 16'd0) || align_err;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ReqReady  = 1'b0;
    RspValid  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemAddr   = '0;
    MemWData  = '0;
    case (state)
      IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          if (req_err) begin
            state_nxt = RESP;
          end else if (ReqWrite) begin
            state_nxt = WR_HI;
          end else begin
            state_nxt = RD_HI;
          end
        end
      end
      WR_HI: begin
        MemWrite  = 1'b1;
        MemAddr   = addr_q;
        MemWData  = wdata_q[15:8];
        state_nxt = WR_LO;
      end
      WR_LO: begin
        MemWrite  = 1'b1;
        MemAddr   = addr_lo;
        MemWData  = wdata_q[7:0];
        state_nxt = RESP;
      end
      RD_HI: begin
        MemRead   = 1'b1;
        MemAddr   = addr_q;
        state_nxt = RD_LO;
      end
      RD_LO: begin
        MemRead   = 1'b1;
        MemAddr   = addr_lo;
        state_nxt = RD_CAP;
      end
      RD_CAP: begin
        state_nxt = RESP;
      end
      RESP: begin
        RspValid  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Read data arrives one clock after its strobe, so each byte is captured a state later.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      RspData <= '0;
      RspErr  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= ReqAddr[ADDR_W-1:0];
        wdata_q <= ReqWData;
        RspData <= '0;
        RspErr  <= req_err;
      end
      if (state == RD_LO) begin
        RspData[15:8] <= MemRData;
      end
      if (state == RD_CAP) begin
        RspData[7:0] <= MemRData;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a synchronous byte-memory model.
module tb_mem_access_unit;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqWrite = 1'b0;
  logic [15:0] ReqAddr = 16'h0000;
  logic [15:0] ReqWData = 16'h0000;
  logic        ReqReady;
  logic        RspValid;
  logic [15:0] RspData;
  logic        RspErr;
  logic [6:0]  MemAddr;
  logic [7:0]  MemWData;
  logic        MemRead;
  logic        MemWrite;
  logic [7:0]  MemRData = 8'h00;

  mem_access_unit #(.ADDR_W(7), .MEM_BYTES(128)) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .ReqValid (ReqValid),
    .ReqReady (ReqReady),
    .ReqWrite (ReqWrite),
    .ReqAddr  (ReqAddr),
    .ReqWData (ReqWData),
    .RspValid (RspValid),
    .RspData  (RspData),
    .RspErr   (RspErr),
    .MemAddr  (MemAddr),
    .MemWData (MemWData),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .MemRData (MemRData)
  );

  typedef struct {
    logic        err;
    logic [15:0] data;
    int          lat;
  } exp_t;

  typedef struct {
    logic [6:0] a;
    logic [7:0] d;
    int         c;
  } wlog_t;

  logic [7:0] mem [0:127];
  exp_t       exp_q[$];
  int         acc_q[$];
  wlog_t      wlog[$];
  exp_t       mon_e;
  int         mon_a;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int both_cnt = 0;
  int rdybusy_cnt = 0;
  int acc_cnt = 0;

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    cyc <= cyc + 1;
    if (MemWrite) mem[MemAddr] <= MemWData;
    if (MemRead) MemRData <= mem[MemAddr];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (Reset_n) begin
      if (MemWrite) begin
        wr_cnt++;
        wlog.push_back('{MemAddr, MemWData, cyc});
      end
      if (MemRead) rd_cnt++;
      if (MemRead && MemWrite) both_cnt++;
      if (ReqReady && (MemRead || MemWrite)) rdybusy_cnt++;
      if (ReqValid && ReqReady) begin
        acc_cnt++;
        acc_q.push_back(cyc);
      end
      if (RspValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got RspValid=1 expected no response (t=%0t)", $time);
        end else begin
          mon_e = exp_q.pop_front();
          mon_a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
          chk("rsp_err", int'(RspErr), int'(mon_e.err));
          chk("rsp_data", int'(RspData), int'(mon_e.data));
          chk("rsp_latency", cyc - mon_a, mon_e.lat);
        end
      end
    end
  end

  task automatic wait_accept();
    int n;
    n = 0;
    forever begin
      @(negedge Clock);
      if (ReqReady) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got ReqReady=0 expected 1 within 50 cycles");
        break;
      end
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic ee, input logic [15:0] ed, input int lat);
    exp_q.push_back('{ee, ed, lat});
    ReqWrite = w;
    ReqAddr  = a;
    ReqWData = d;
    ReqValid = 1'b1;
    wait_accept();
    ReqValid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge Clock);
    #1;
    chk("drain_pending", exp_q.size(), 0);
  endtask

  int w0, r0, a0;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[7'h21] = 8'h5A;
    mem[7'h22] = 8'hC3;
    mem[7'h7E] = 8'h12;
    mem[7'h7F] = 8'h34;

    // Reset values
    #3;
    chk("rst_ready", int'(ReqReady), 1);
    chk("rst_rspvalid", int'(RspValid), 0);
    chk("rst_rsperr", int'(RspErr), 0);
    chk("rst_rspdata", int'(RspData), 0);
    chk("rst_strobes", int'({MemRead, MemWrite}), 0);
    chk("rst_memaddr", int'(MemAddr), 0);
    chk("rst_memwdata", int'(MemWData), 0);
    repeat (2) @(posedge Clock);
    #1 Reset_n = 1'b1;
    @(posedge Clock);
    #1;

    // Asynchronous reset in the middle of RD_LO
    ReqWrite = 1'b0;
    ReqAddr  = 16'h0010;
    ReqValid = 1'b1;
    wait_accept();
    ReqValid = 1'b0;
    @(posedge Clock);
    #1;
    chk("rdlo_memread", int'(MemRead), 1);
    chk("rdlo_ready", int'(ReqReady), 0);
    Reset_n = 1'b0;
    #1;
    chk("arst_ready", int'(ReqReady), 1);
    chk("arst_strobes", int'({MemRead, MemWrite}), 0);
    chk("arst_rspvalid", int'(RspValid), 0);
    chk("arst_memaddr", int'(MemAddr), 0);
    @(posedge Clock);
    #1 Reset_n = 1'b1;
    acc_q.delete();
    @(posedge Clock);
    #1;

    // Store 0xBEEF at 0x10
    w0 = wr_cnt;
    wlog.delete();
    issue(1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 3);
    drain();
    chk("st_wr_pulses", wr_cnt - w0, 2);
    chk("st_log_size", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      chk("st_hi_addr", int'(wlog[0].a), 'h10);
      chk("st_hi_data", int'(wlog[0].d), 'hBE);
      chk("st_lo_addr", int'(wlog[1].a), 'h11);
      chk("st_lo_data", int'(wlog[1].d), 'hEF);
      chk("st_consecutive", wlog[1].c - wlog[0].c, 1);
    end

    // Loads: readback and highest legal pair
    issue(1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF, 4);
    issue(1'b0, 16'h007E, 16'h0000, 1'b0, 16'h1234, 4);
    drain();

    // Rejected requests make no memory access
    w0 = wr_cnt;
    r0 = rd_cnt;
    issue(1'b1, 16'h007F, 16'hAAAA, 1'b1, 16'h0000, 1);
    issue(1'b0, 16'h007F, 16'h0000, 1'b1, 16'h0000, 1);
    issue(1'b0, 16'h0080, 16'h0000, 1'b1, 16'h0000, 1);
    issue(1'b1, 16'hFFFF, 16'h5555, 1'b1, 16'h0000, 1);
    drain();
    chk("err_no_write", wr_cnt - w0, 0);
    chk("err_no_read", rd_cnt - r0, 0);
    chk("err_mem_7f", int'(mem[7'h7F]), 'h34);
    repeat (3) @(posedge Clock);
    #1;
    chk("err_hold", int'(RspErr), 1);

    // Odd address
    w0 = wr_cnt;
    r0 = rd_cnt;
`ifdef ALIGN_CHECK_EN
    issue(1'b0, 16'h0021, 16'h0000, 1'b1, 16'h0000, 1);
    drain();
    chk("odd_no_read", rd_cnt - r0, 0);
`else
    issue(1'b0, 16'h0021, 16'h0000, 1'b0, 16'h5AC3, 4);
    drain();
    chk("odd_reads", rd_cnt - r0, 2);
`endif

    // Three stores with ReqValid held high
    a0 = acc_cnt;
    w0 = wr_cnt;
    exp_q.push_back('{1'b0, 16'h0000, 3});
    exp_q.push_back('{1'b0, 16'h0000, 3});
    exp_q.push_back('{1'b0, 16'h0000, 3});
    ReqWrite = 1'b1;
    ReqAddr  = 16'h0040;
    ReqWData = 16'h1122;
    ReqValid = 1'b1;
    wait_accept();
    ReqAddr  = 16'h0042;
    ReqWData = 16'h3344;
    wait_accept();
    ReqAddr  = 16'h0044;
    ReqWData = 16'h5566;
    wait_accept();
    ReqValid = 1'b0;
    drain();
    chk("b2b_accepts", acc_cnt - a0, 3);
    chk("b2b_wr_pulses", wr_cnt - w0, 6);
    chk("b2b_mem_41", int'(mem[7'h41]), 'h22);
    chk("b2b_mem_42", int'(mem[7'h42]), 'h33);
    chk("b2b_mem_45", int'(mem[7'h45]), 'h66);
    chk("ready_while_busy", rdybusy_cnt, 0);
    chk("rd_wr_overlap", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
